// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and frame-length lookup for the UART command sequencer.
package uart_cmd_pkg;

  localparam logic [7:0] OP_TRIG = 8'h5C;
  localparam logic [7:0] OP_SET  = 8'h53;
  localparam logic [7:0] OP_READ = 8'hA5;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    EXEC,
    TX_LOAD,
    TX_WAIT
  } state_t;

  // Total bytes in a frame including the opcode; 0 marks an unknown opcode.
  function automatic logic [2:0] frame_len(input logic [7:0] op);
    case (op)
      OP_TRIG, OP_READ: frame_len = 3'd2;
      OP_SET:           frame_len = 3'd4;
      default:          frame_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// UART buffer side of the sequencer: received-byte strobe in, transmit request out.
interface uart_cmd_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (output rx_data, rx_valid, tx_busy, input tx_data, tx_start);
  modport slave  (input rx_data, rx_valid, tx_busy, output tx_data, tx_start);
endinterface

// File: rtl/uart_cmd_sequencer_timeout.sv
// Loadable down-counter; expire pulses in the cycle the count would pass 1 -> 0 while enabled.
module uart_cmd_timeout #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [TO_W-1:0] load_val,
  output logic            expire
);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - TO_W'(1);
  end

  assign expire = en && !load && (count == TO_W'(1));

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames UART bytes into trigger/vector commands, applies them and sequences reply bytes.
// Optional CMD_ACK_EN: every completed write frame answers with ACK, bad frames with NAK.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 40000,
  parameter int TO_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_sequencer_if.slave  uart,
  output logic [7:0]           trigout_ch0,
  output logic [7:0]           trigout_ch1,
  output logic [7:0]           trigout_ch2,
  output logic [7:0]           trigout_ch3,
  output logic [7:0]           vctrout_ch0,
  output logic [7:0]           vctrout_ch1,
  output logic [7:0]           vctrout_ch2,
  output logic [7:0]           vctrout_ch3,
  output logic                 trig_en,
  output logic                 busy,
  output logic                 idle,
  output logic [2:0]           byte_count,
  output logic                 cmd_err
);

  state_t     state, state_nxt;
  logic [7:0] opcode;
  logic [7:0] args [3];
  logic [7:0] trig_r [4];
  logic [7:0] vctr_r [4];
  logic [7:0] resp [3];
  logic [1:0] resp_len, resp_idx, idx_nxt, exec_len;
  logic [2:0] count_nxt;
  logic       seen_busy, seen_nxt;
  logic       err_nxt, start_nxt, to_load, to_expire;
  logic [7:0] data_nxt;
  logic [1:0] ch;
  logic       ch_ok, arg_ok, frame_ok;

  uart_cmd_timeout #(.TO_W(TO_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .en       (state == COLLECT || state == TX_WAIT),
    .load_val (TO_W'(TIMEOUT_CYC)),
    .expire   (to_expire)
  );

  assign ch       = args[0][1:0];
  assign ch_ok    = (args[0][7:2] == 6'd0);
  assign arg_ok   = (args[0][7:1] == 7'd0);
  assign frame_ok = (opcode == OP_TRIG) ? arg_ok : ch_ok;

`ifdef CMD_ACK_EN
  assign exec_len = (opcode == OP_READ && frame_ok) ? 2'd3 : 2'd1;
`else
  assign exec_len = (opcode == OP_READ && frame_ok) ? 2'd3 : 2'd0;
`endif

  always_comb begin
    state_nxt = state;
    count_nxt = byte_count;
    idx_nxt   = resp_idx;
    seen_nxt  = seen_busy;
    err_nxt   = 1'b0;
    start_nxt = 1'b0;
    data_nxt  = uart.tx_data;
    to_load   = 1'b0;
    case (state)
      IDLE: if (uart.rx_valid) begin
        if (frame_len(uart.rx_data) != 3'd0) begin
          state_nxt = COLLECT;
          count_nxt = 3'd1;
          to_load   = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      COLLECT: if (uart.rx_valid) begin
        count_nxt = byte_count + 3'd1;
        to_load   = 1'b1;
        if (byte_count + 3'd1 == frame_len(opcode))
          state_nxt = EXEC;
      end else if (to_expire) begin
        err_nxt   = 1'b1;
        count_nxt = 3'd0;
        state_nxt = IDLE;
      end
      EXEC: begin
        err_nxt = !frame_ok;
        idx_nxt = 2'd0;
        if (exec_len != 2'd0) begin
          state_nxt = TX_LOAD;
        end else begin
          state_nxt = IDLE;
          count_nxt = 3'd0;
        end
      end
      TX_LOAD: if (!uart.tx_busy) begin
        start_nxt = 1'b1;
        data_nxt  = resp[resp_idx];
        seen_nxt  = 1'b0;
        to_load   = 1'b1;
        state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (uart.tx_busy)
          seen_nxt = 1'b1;
        // A transmitter that never raises busy must not stall the reply forever.
        if ((seen_busy && !uart.tx_busy) || (to_expire && !seen_busy && !uart.tx_busy)) begin
          if (resp_idx == resp_len - 2'd1) begin
            state_nxt = IDLE;
            count_nxt = 3'd0;
          end else begin
            idx_nxt   = resp_idx + 2'd1;
            state_nxt = TX_LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (uart.rx_valid && (state == EXEC || state == TX_LOAD || state == TX_WAIT))
      err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      opcode        <= 8'h00;
      byte_count    <= 3'd0;
      resp_len      <= 2'd0;
      resp_idx      <= 2'd0;
      seen_busy     <= 1'b0;
      cmd_err       <= 1'b0;
      trig_en       <= 1'b0;
      uart.tx_data  <= 8'h00;
      uart.tx_start <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        args[i] <= 8'h00;
        resp[i] <= 8'h00;
      end
      for (int i = 0; i < 4; i++) begin
        trig_r[i] <= 8'h00;
        vctr_r[i] <= 8'h00;
      end
    end else begin
      state         <= state_nxt;
      byte_count    <= count_nxt;
      resp_idx      <= idx_nxt;
      seen_busy     <= seen_nxt;
      cmd_err       <= err_nxt;
      uart.tx_data  <= data_nxt;
      uart.tx_start <= start_nxt;
      if (state == IDLE && uart.rx_valid)
        opcode <= uart.rx_data;
      if (state == COLLECT && uart.rx_valid)
        args[byte_count[1:0] - 2'd1] <= uart.rx_data;
      if (state == EXEC) begin
        resp_len <= exec_len;
        resp[0]  <= (opcode == OP_READ && frame_ok) ? OP_READ : (frame_ok ? ACK : NAK);
        resp[1]  <= trig_r[ch];
        resp[2]  <= vctr_r[ch];
        if (frame_ok && opcode == OP_TRIG)
          trig_en <= args[0][0];
        if (frame_ok && opcode == OP_SET) begin
          trig_r[ch] <= args[1];
          vctr_r[ch] <= args[2];
        end
      end
    end
  end

  assign trigout_ch0 = trig_r[0];
  assign trigout_ch1 = trig_r[1];
  assign trigout_ch2 = trig_r[2];
  assign trigout_ch3 = trig_r[3];
  assign vctrout_ch0 = vctr_r[0];
  assign vctrout_ch1 = vctr_r[1];
  assign vctrout_ch2 = vctr_r[2];
  assign vctrout_ch3 = vctr_r[3];
  assign idle        = (state == IDLE);
  assign busy        = (state != IDLE);

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Command-layer controller between the UART receive/transmit buffer and the per-channel trigger/vector configuration registers.
- Collects received bytes into framed commands and applies them to four channels' trig/vctr registers and the global trigger enable.
- Sequences read-back and acknowledge bytes to the UART transmitter.
- Aborts partial frames on inter-byte timeout.

Parameters:
- TIMEOUT_CYC, 40000, max clk cycles between bytes of one frame (≈3.3 ms at 12 MHz, >3 byte times at 9600 baud).
- TO_W, 16, width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock (12 MHz)
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte from UART buffer
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_busy  in  1  UART transmitter busy
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle strobe requesting transmission of tx_data
- trigout_ch0..trigout_ch3  out  8 each  trigger value per channel
- vctrout_ch0..vctrout_ch3  out  8 each  vector value per channel
- trig_en  out  1  global trigger enable
- busy  out  1  high whenever state != IDLE
- idle  out  1  high in IDLE
- byte_count  out  3  bytes accepted in current frame
- cmd_err  out  1  one-cycle strobe on bad opcode, bad channel or timeout

Behaviour:
- Reset (async, rst=1): all trigout/vctrout = 8'h00, trig_en=0, tx_data=8'h00, tx_start=0, byte_count=0, cmd_err=0, state=IDLE, idle=1, busy=0.
- Frame formats (first byte = opcode):
  - 0x5C, arg: arg 0x00 → trig_en=0; 0x01 → trig_en=1; other values → cmd_err.
  - 0x53, ch, trig, vctr: write trigout_ch[ch]=trig and vctrout_ch[ch]=vctr, both in the same cycle.
  - 0xA5, ch: read-back; transmit 0xA5, trigout_ch[ch], vctrout_ch[ch] in that order.
  - ch is valid 0..3; ch>3 → cmd_err, no register change.
- States: IDLE, COLLECT, EXEC, TX_LOAD, TX_WAIT.
- IDLE:
  - rx_valid with a known opcode → latch opcode, byte_count=1, go to COLLECT.
  - rx_valid with an unknown opcode → cmd_err pulse, stay in IDLE.
  - Bytes received with rx_valid low are ignored.
- COLLECT:
  - Each rx_valid stores the byte into arg[byte_count-1] and increments byte_count.
  - When byte_count reaches the frame length (2 or 4), go to EXEC on the next cycle.
  - The timeout counter clears on each rx_valid. If it reaches TIMEOUT_CYC: cmd_err pulse, byte_count=0, go to IDLE; partial frame discarded, no register written.
- EXEC: single cycle; registers update at the end of the EXEC cycle (outputs visible 1 cycle after the final byte's rx_valid cycle + 1). Then go to TX_LOAD if a response is queued, else IDLE.
- TX_LOAD: when tx_busy=0, drive tx_data and pulse tx_start for one cycle, then go to TX_WAIT.
- TX_WAIT:
  - Wait for tx_busy to rise, then fall; then go to the next response byte (TX_LOAD) or to IDLE.
  - tx_busy not seen high within TIMEOUT_CYC → proceed as if the byte completed.
- rx_valid during EXEC/TX_LOAD/TX_WAIT: byte dropped, cmd_err pulse; no queueing.
- byte_count returns to 0 on entry to IDLE.
- Register writes are atomic per frame; there is no write to any other channel.
- rst asserted mid-frame or mid-transmission: immediate return to reset values, including the config registers.

Optional Feature:
- Macro CMD_ACK_EN.
- Defined: after every successful 0x5C/0x53 frame, transmit 0x06 (ACK). After a bad-argument or bad-channel frame, transmit 0x15 (NAK); cmd_err still pulses. Timeout and unknown opcode produce no byte.
- Undefined: write frames produce no transmission; only 0xA5 read-back uses the transmitter.

Decomposition:
- Shared package uart_cmd_pkg:
  - opcode constants OP_TRIG=8'h5C, OP_SET=8'h53, OP_READ=8'hA5, ACK=8'h06, NAK=8'h15
  - state encoding
  - frame-length function
- Sub-module uart_cmd_timeout: loadable down-counter with expiry strobe, reused by COLLECT and TX_WAIT.

Test Plan:
- Frame 0x5C,0x01 → trig_en 0→1 two cycles after last rx_valid; then 0x5C,0x00 → trig_en=0; 0x5C,0x07 → cmd_err, trig_en unchanged.
- Frame 0x53,0x02,0xCC,0x11 → trigout_ch2=0xCC, vctrout_ch2=0x11; other channels remain 0x00.
- 0x53,0x02,0xCC,0x11 then 0xA5,0x02 → tx_start pulses three times, tx_data 0xA5, 0xCC, 0x11 in order, each issued only when tx_busy=0.
- Send 0x53,0x01 then silence TIMEOUT_CYC cycles → cmd_err one cycle, idle=1, byte_count=0; then 0x53,0x01,0x55,0x66 applies normally.
- Frame 0x53,0x05,0xAA,0xBB → cmd_err, no register change. With CMD_ACK_EN: one tx byte 0x15. Valid write with CMD_ACK_EN: one tx byte 0x06.
- rst pulse asserted during the third byte of a 0x53 frame → all outputs at reset values asynchronously; a subsequent full frame decodes correctly.
